// File: rtl/uart_cfg_pkg.sv
// Shared encodings for the configurable UART transmitter: parity modes, serializer states.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // Width of the bit-period input; never narrower than one bit.
  function automatic int unsigned cpb_width(input int unsigned limit);
    return ($clog2(limit) > 0) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// FIFO write-side bundle: push strobe, frame data and occupancy status.
interface uart_tx_cfg_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned BUFSZ     = 2
);
  localparam int unsigned UW = $clog2(BUFSZ) + 1;

  logic                 push_i;
  logic [DATAWIDTH-1:0] data_i;
  logic                 full_o;
  logic                 empty_o;
  logic [UW-1:0]        usage_o;

  modport master (output push_i, data_i, input full_o, empty_o, usage_o);
  modport slave  (input push_i, data_i, output full_o, empty_o, usage_o);
endinterface

// File: rtl/uart_tx_cfg_ser.sv
// Frame serializer: pops one frame, latches its configuration and shifts it onto tx_o.
module uart_tx_cfg_ser import uart_cfg_pkg::*; #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned CPBW      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CPBW-1:0]      clockcyclesperbit_i,
  input  logic [3:0]           databits_i,
  input  logic [2:0]           parity_i,
  input  logic                 stopbits_i,
  input  logic                 break_i,
  input  logic                 empty_i,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic                 pop_c,
  output logic                 busy_o,
  output logic                 tx_o
);

  state_e               state;
  logic [DATAWIDTH-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic [3:0]           last_bit;
  logic [CPBW-1:0]      per_cnt;
  logic [CPBW-1:0]      per_last;
  logic                 has_par;
  logic                 par_bit;
  logic                 stop2;

  logic [3:0]           d_c;
  logic [CPBW-1:0]      per_last_c;
  logic                 even_c;
  logic                 has_par_c;
  logic                 par_bit_c;
  logic                 per_done_c;
  logic                 stop_done_c;

  // Configuration of the frame at the FIFO head, as it would be latched on a pop.
  always_comb begin
    d_c = databits_i;
    if (d_c < 4'd5) d_c = 4'd5;
    else if (d_c > 4'(DATAWIDTH)) d_c = 4'(DATAWIDTH);
    per_last_c = (clockcyclesperbit_i == '0) ? '0 : clockcyclesperbit_i - CPBW'(1);
    even_c = 1'b0;
    for (int i = 0; i < int'(DATAWIDTH); i++) begin
      if (4'(i) < d_c) even_c = even_c ^ data_i[i];
    end
    has_par_c = 1'b1;
    par_bit_c = 1'b0;
    case (parity_i)
      PAR_EVEN:  par_bit_c = even_c;
      PAR_ODD:   par_bit_c = ~even_c;
      PAR_MARK:  par_bit_c = 1'b1;
      PAR_SPACE: par_bit_c = 1'b0;
      default:   has_par_c = 1'b0;
    endcase
    per_done_c  = (per_cnt == per_last);
    stop_done_c = (state == ST_STOP) && per_done_c && !(stop2 && (bit_cnt == 4'd0));
    pop_c       = ((state == ST_IDLE) || stop_done_c) && !break_i && !empty_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      per_cnt  <= '0;
      per_last <= '0;
      has_par  <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
    end else if ((state == ST_IDLE) || stop_done_c) begin
      // Frame boundary: break wins over queued data, otherwise start the next frame at once.
      per_cnt <= '0;
      if (break_i) begin
        state    <= ST_BREAK;
        tx_o     <= 1'b0;
        busy_o   <= 1'b1;
        per_last <= per_last_c;
      end else if (!empty_i) begin
        state    <= ST_START;
        tx_o     <= 1'b0;
        busy_o   <= 1'b1;
        shreg    <= data_i;
        last_bit <= d_c - 4'd1;
        per_last <= per_last_c;
        has_par  <= has_par_c;
        par_bit  <= par_bit_c;
        stop2    <= stopbits_i;
      end else begin
        state  <= ST_IDLE;
        tx_o   <= 1'b1;
        busy_o <= 1'b0;
      end
    end else begin
      per_cnt <= per_done_c ? '0 : per_cnt + CPBW'(1);
      case (state)
        ST_START: if (per_done_c) begin
          state   <= ST_DATA;
          tx_o    <= shreg[0];
          bit_cnt <= '0;
        end
        ST_DATA: if (per_done_c) begin
          if (bit_cnt == last_bit) begin
            bit_cnt <= '0;
            if (has_par) begin
              state <= ST_PARITY;
              tx_o  <= par_bit;
            end else begin
              state <= ST_STOP;
              tx_o  <= 1'b1;
            end
          end else begin
            shreg   <= shreg >> 1;
            tx_o    <= shreg[1];
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_PARITY: if (per_done_c) begin
          state   <= ST_STOP;
          tx_o    <= 1'b1;
          bit_cnt <= '0;
        end
        ST_STOP: if (per_done_c) bit_cnt <= 4'd1;
        ST_BREAK: begin
          per_cnt <= '0;
          if (!break_i) begin
            state   <= ST_STOP;
            tx_o    <= 1'b1;
            bit_cnt <= '0;
            stop2   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: inline frame FIFO feeding the serializer sub-module.
module uart_tx_cfg import uart_cfg_pkg::*; #(
  parameter int unsigned BUFSZ                  = 2,
  parameter int unsigned DATAWIDTH              = 8,
  parameter int unsigned CLOCKCYCLESPERBITLIMIT = 2
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic [cpb_width(CLOCKCYCLESPERBITLIMIT)-1:0]   clockcyclesperbit_i,
  input  logic [3:0]                                     databits_i,
  input  logic [2:0]                                     parity_i,
  input  logic                                           stopbits_i,
  input  logic                                           break_i,
  uart_tx_cfg_if.slave                                   bus,
  output logic                                           busy_o,
  output logic                                           tx_o
);

  localparam int unsigned AW   = $clog2(BUFSZ);
  localparam int unsigned UW   = AW + 1;
  localparam int unsigned CPBW = cpb_width(CLOCKCYCLESPERBITLIMIT);

  logic [DATAWIDTH-1:0] mem [BUFSZ];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [UW-1:0]        usage;
  logic [UW-1:0]        usage_n_c;
  logic                 full;
  logic                 empty;
  logic                 push_ok_c;
  logic                 pop_c;

  always_comb begin
    push_ok_c = bus.push_i && !full;
    case ({push_ok_c, pop_c})
      2'b10:   usage_n_c = usage + UW'(1);
      2'b01:   usage_n_c = usage - UW'(1);
      default: usage_n_c = usage;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      usage <= usage_n_c;
      full  <= (usage_n_c == UW'(BUFSZ));
      empty <= (usage_n_c == '0);
    end
  end

  // Storage needs no reset; pointers and flags define what is valid.
  always_ff @(posedge clk_i) begin
    if (rst_i && push_ok_c) mem[wr_ptr] <= bus.data_i;
  end

  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.usage_o = usage;

  uart_tx_cfg_ser #(
    .DATAWIDTH (DATAWIDTH),
    .CPBW      (CPBW)
  ) u_ser (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .clockcyclesperbit_i (clockcyclesperbit_i),
    .databits_i          (databits_i),
    .parity_i            (parity_i),
    .stopbits_i          (stopbits_i),
    .break_i             (break_i),
    .empty_i             (empty),
    .data_i              (mem[rd_ptr]),
    .pop_c               (pop_c),
    .busy_o              (busy_o),
    .tx_o                (tx_o)
  );

endmodule
